nibble_add_sched: RTL and testbench
===================================

NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 SHALL have parameter: NIB, 4, number of 4-bit nibbles per operand (legal 2..8); W = 4*NIB.
REQ-002 SHALL have port: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req0_valid / req1_valid  in  1  requester N presents an operation.
REQ-005 SHALL have ports: req0_ready / req1_ready  out  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports: req0_a, req0_b, req1_a, req1_b  in  W  operands of requester N.
REQ-007 SHALL have ports: req0_sub / req1_sub  in  1  subtract select; present only when NIBBLE_SUB_EN is defined.
REQ-008 SHALL have port: rsp_valid  out  1  result available.
REQ-009 SHALL have port: rsp_ready  in  1  consumer accepts result.
REQ-010 SHALL have port: rsp_id  out  1  index of the requester that owns the result.
REQ-011 SHALL have port: rsp_sum  out  W  result.
REQ-012 SHALL have port: rsp_cout  out  1  carry out of the most significant nibble.
REQ-013 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-014 SHALL share one internal 4-bit ripple full-adder slice across all nibbles and requesters; no W-bit adder is permitted.
REQ-015 SHALL implement FSM IDLE -> RUN -> RESP -> IDLE.
REQ-016 IDLE: if any reqN_valid, grant one requester, assert only its reqN_ready combinationally in that cycle, latch its a/b/id (and sub), clear nibble index, set carry to 0, go to RUN.
REQ-017 Arbitration: single valid requester wins; both valid -> requester not granted last wins (round robin).
REQ-018 reqN_ready SHALL be 0 outside IDLE and for any non-granted requester.
REQ-019 RUN: each cycle add nibble[i] of a and b plus carry, store sum nibble i, register carry, i++; after nibble NIB-1 go to RESP (RUN lasts exactly NIB cycles).
REQ-020 RESP: rsp_valid=1 with rsp_sum, rsp_cout, rsp_id held stable until rsp_valid & rsp_ready; then go to IDLE.
REQ-021 Latency: accept handshake in cycle T -> rsp_valid high in cycle T+NIB+1 (5 cycles at NIB=4).
REQ-022 No request SHALL be accepted in the cycle a response is consumed; earliest next accept is the following IDLE cycle (max throughput one op per NIB+2 cycles).
REQ-023 Sum SHALL wrap modulo 2^W; overflow reported only via rsp_cout.
REQ-024 rsp_valid SHALL be 0 in IDLE and RUN; rsp_sum/rsp_cout/rsp_id hold last values outside RESP.

Reset
REQ-025 rst high SHALL immediately force state IDLE, nibble index 0, carry 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, req0_ready/req1_ready 0, busy 0.
REQ-026 Round-robin pointer SHALL reset so requester 0 wins the first two-way contention.
REQ-027 Reset during RUN or RESP SHALL abandon the operation with no response ever emitted for it.

Configuration
REQ-028 Macro NIBBLE_SUB_EN defined: reqN_sub ports exist; when latched sub=1, b is inverted per nibble and initial carry is 1 (a-b mod 2^W), rsp_cout=1 means no borrow.
REQ-029 Macro NIBBLE_SUB_EN undefined: reqN_sub ports absent, add-only, initial carry always 0.

Verification (NIB=4)
REQ-030 req0 a=0x1234 b=0x0FFF -> rsp_sum=0x2233, rsp_cout=0, rsp_id=0, rsp_valid exactly 5 cycles after handshake.
REQ-031 req1 a=0xFFFF b=0x0001 -> rsp_sum=0x0000, rsp_cout=1, rsp_id=1 (carry ripples through all 4 nibbles).
REQ-032 both requesters held valid, rsp_ready=1 -> grants 0,1,0,1 with results matching each requester's operands.
REQ-033 rsp_ready held 0 for 3 cycles in RESP -> rsp_valid/rsp_sum/rsp_id stable, both reqN_ready 0, busy 1; accept -> IDLE next cycle.
REQ-034 rst pulsed in 2nd RUN cycle -> all outputs 0 at once, no rsp_valid afterwards; next request 0x0001+0x0001 -> rsp_sum=0x0002 normally.
REQ-035 NIBBLE_SUB_EN defined, req0 sub=1 a=0x0005 b=0x0007 -> rsp_sum=0xFFFE, rsp_cout=0; a=0x0007 b=0x0005 -> 0x0002, rsp_cout=1.

Source files
------------

// File: rtl/nibble_add_sched.sv
// Two-requester, nibble-serial adder that shares one 4-bit ripple slice and takes NIB cycles per operation.
// Define NIBBLE_SUB_EN to add the per-requester subtract select (a - b mod 2^W).
module nibble_add_sched #(
   parameter int NIB = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [4*NIB-1:0] req0_a,
   input  logic [4*NIB-1:0] req0_b,
   input  logic [4*NIB-1:0] req1_a,
   input  logic [4*NIB-1:0] req1_b,
`ifdef NIBBLE_SUB_EN
   input  logic             req0_sub,
   input  logic             req1_sub,
`endif
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [4*NIB-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             busy
);

   localparam int W  = 4 * NIB;
   localparam int IW = $clog2(NIB);

   typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] idx_q;
   logic          carry_q;
   logic          sub_q;
   logic          id_q;
   logic          rr_last_q;
   logic [W-1:0]  a_q, b_q, acc_q;

   logic          grant0, grant1;
   logic          last_nib;
   logic          sub0, sub1;
   logic [3:0]    a_nib, b_nib, s_nib;
   logic          c_out;

`ifdef NIBBLE_SUB_EN
   assign sub0 = req0_sub;
   assign sub1 = req1_sub;
`else
   assign sub0 = 1'b0;
   assign sub1 = 1'b0;
`endif

   assign last_nib = (idx_q == IW'(NIB - 1));

   // FSM next state and grant; rr_last_q high means requester 1 was granted last.
   always_comb begin
      state_d = state_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_valid && (!req1_valid || rr_last_q)) grant0 = 1'b1;
            else if (req1_valid)                          grant1 = 1'b1;
            if (grant0 || grant1) state_d = RUN;
         end
         RUN:     if (last_nib)  state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: ready is a combinational path from the grant; gating with rst keeps it low while reset is asserted.
   assign req0_ready = grant0 & ~rst;
   assign req1_ready = grant1 & ~rst;
   assign rsp_valid  = (state_q == RESP);
   assign busy       = (state_q != IDLE);

   // Operands shift right one nibble per RUN cycle, so the slice always sees the low nibble.
   assign a_nib = a_q[3:0];
   assign b_nib = b_q[3:0] ^ {4{sub_q}};

   // NOTE: blocking assignments inside always_comb model the ripple chain in order; c gets its value first.
   always_comb begin
      logic c;
      c     = carry_q;
      s_nib = 4'h0;
      for (int k = 0; k < 4; k++) begin
         s_nib[k] = a_nib[k] ^ b_nib[k] ^ c;
         c        = (a_nib[k] & b_nib[k]) | (c & (a_nib[k] ^ b_nib[k]));
      end
      c_out = c;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         carry_q   <= 1'b0;
         sub_q     <= 1'b0;
         id_q      <= 1'b0;
         rr_last_q <= 1'b1;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_id    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant0 || grant1) begin
                  a_q       <= grant1 ? req1_a : req0_a;
                  b_q       <= grant1 ? req1_b : req0_b;
                  sub_q     <= grant1 ? sub1 : sub0;
                  carry_q   <= grant1 ? sub1 : sub0;
                  id_q      <= grant1;
                  rr_last_q <= grant1;
                  idx_q     <= '0;
               end
            end
            RUN: begin
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               acc_q   <= {s_nib, acc_q[W-1:4]};
               carry_q <= c_out;
               idx_q   <= idx_q + 1'b1;
               // Result registers only change on entry to RESP, so they hold between operations.
               if (last_nib) begin
                  rsp_sum  <= {s_nib, acc_q[W-1:4]};
                  rsp_cout <= c_out;
                  rsp_id   <= id_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed self-checking bench for nibble_add_sched at NIB=4; covers the subtract path when NIBBLE_SUB_EN is defined.
module tb_nibble_add_sched;

   localparam int NIB = 4;
   localparam int W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
`ifdef NIBBLE_SUB_EN
   logic         req0_sub = 1'b0, req1_sub = 1'b0;
`endif
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic         rsp_id;
   logic [W-1:0] rsp_sum;
   logic         rsp_cout;
   logic         busy;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   nibble_add_sched #(.NIB(NIB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
`ifdef NIBBLE_SUB_EN
      .req0_sub   (req0_sub),
      .req1_sub   (req1_sub),
`endif
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic [W-1:0] s, input logic c, input logic id);
      check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_sum"},   32'(rsp_sum),   32'(s));
      check({tag, "_cout"},  32'(rsp_cout),  32'(c));
      check({tag, "_id"},    32'(rsp_id),    32'(id));
      check({tag, "_busy"},  32'(busy),      32'd1);
   endtask

   task automatic chk_idle_zero(input string tag);
      check({tag, "_valid"}, 32'(rsp_valid),  32'd0);
      check({tag, "_busy"},  32'(busy),       32'd0);
      check({tag, "_rdy0"},  32'(req0_ready), 32'd0);
      check({tag, "_rdy1"},  32'(req1_ready), 32'd0);
      check({tag, "_sum"},   32'(rsp_sum),    32'd0);
      check({tag, "_cout"},  32'(rsp_cout),   32'd0);
      check({tag, "_id"},    32'(rsp_id),     32'd0);
   endtask

   initial begin
      // Reset with a request pending: nothing may be granted.
      #1 rst = 1'b1;
      req0_valid = 1'b1;
      #1;
      chk_idle_zero("reset");
      tick();
      tick();
      rst        = 1'b0;
      req0_valid = 1'b0;
      #1;

      // req0: 0x1234 + 0x0FFF, response held back by rsp_ready=0.
      req0_a = 16'h1234; req0_b = 16'h0FFF; req0_valid = 1'b1;
      #1;
      check("op1_rdy0", 32'(req0_ready), 32'd1);
      check("op1_rdy1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      #1;
      check("op1_run_busy", 32'(busy), 32'd1);
      check("op1_run_rdy0", 32'(req0_ready), 32'd0);
      for (int k = 1; k <= 3; k++) begin
         check("op1_run_valid", 32'(rsp_valid), 32'd0);
         tick();
      end
      check("op1_run_valid", 32'(rsp_valid), 32'd0);
      tick();

      // RESP held for 3 cycles with a competing request from req1.
      req1_a = 16'hFFFF; req1_b = 16'h0001; req1_valid = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk_rsp("op1_hold", 16'h2233, 1'b0, 1'b0);
         check("op1_hold_rdy0", 32'(req0_ready), 32'd0);
         check("op1_hold_rdy1", 32'(req1_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk_rsp("op1_accept", 16'h2233, 1'b0, 1'b0);
      check("op1_accept_rdy1", 32'(req1_ready), 32'd0);
      tick();
      check("op1_idle_valid", 32'(rsp_valid), 32'd0);
      check("op1_idle_busy",  32'(busy), 32'd0);
      check("op1_idle_sum",   32'(rsp_sum), 32'h2233);
      check("op2_rdy1",       32'(req1_ready), 32'd1);
      check("op2_rdy0",       32'(req0_ready), 32'd0);

      // req1: 0xFFFF + 0x0001 ripples a carry through every nibble.
      tick();
      req1_valid = 1'b0;
      repeat (4) tick();
      chk_rsp("op2", 16'h0000, 1'b1, 1'b1);
      tick();

      // Two-way contention with rsp_ready=1: grants alternate 0,1,0,1.
      req0_a = 16'h00FF; req0_b = 16'h0F01;
      req1_a = 16'h8000; req1_b = 16'h8001;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("rr_rdy0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
         check("rr_rdy1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
         tick();
         repeat (4) tick();
         if (k % 2 == 0) chk_rsp("rr_req0", 16'h1000, 1'b0, 1'b0);
         else            chk_rsp("rr_req1", 16'h0001, 1'b1, 1'b1);
         check("rr_resp_rdy0", 32'(req0_ready), 32'd0);
         check("rr_resp_rdy1", 32'(req1_ready), 32'd0);
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Reset in the second RUN cycle abandons the operation.
      req0_a = 16'h4444; req0_b = 16'h1111; req0_valid = 1'b1;
      #1;
      check("abort_rdy0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk_idle_zero("abort_rst");
      tick();
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("abort_no_valid", 32'(rsp_valid), 32'd0);
         check("abort_no_busy",  32'(busy), 32'd0);
      end

      // First contention after reset goes to requester 0.
      req0_a = 16'h0001; req0_b = 16'h0001;
      req1_a = 16'h1111; req1_b = 16'h2222;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check("post_rst_rdy0", 32'(req0_ready), 32'd1);
      check("post_rst_rdy1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (4) tick();
      chk_rsp("post_rst", 16'h0002, 1'b0, 1'b0);
      tick();
      check("post_rst_idle", 32'(busy), 32'd0);

`ifdef NIBBLE_SUB_EN
      // Subtract: 5 - 7 borrows, 7 - 5 does not.
      req0_sub = 1'b1; req0_a = 16'h0005; req0_b = 16'h0007; req0_valid = 1'b1;
      #1;
      check("sub1_rdy0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      repeat (4) tick();
      chk_rsp("sub1", 16'hFFFE, 1'b0, 1'b0);
      tick();
      req0_a = 16'h0007; req0_b = 16'h0005; req0_valid = 1'b1;
      #1;
      check("sub2_rdy0", 32'(req0_ready), 32'd1);
      tick();
      req0_valid = 1'b0;
      repeat (4) tick();
      chk_rsp("sub2", 16'h0002, 1'b1, 1'b0);
      tick();
      req0_sub = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
